evm_multi_candidate_core: RTL
=============================

Name: evm_multi_candidate_core

Overview:
Parametrised electronic-voting-machine core. Generalises the fixed three-candidate EVM to NUM_CAND candidates with a one-hot vote bus and saturating per-candidate tallies. Adds tie detection and range checking on result queries. Sits behind the EVM driver/monitor interface: it consumes the panel controls and produces the results and status outputs.

Parameters:
NUM_CAND, 4, number of candidates (2..16)
WIDTH, 8, tally width in bits; each tally saturates at 2^WIDTH-1
IDX_W, $clog2(NUM_CAND), candidate index width (derived; do not override)

Ports:
clk  input  1  system clock; all logic is posedge
rst  input  1  asynchronous reset, active-low
switch_on_evm  input  1  machine power/enable; low forces IDLE
candidate_ready  input  1  officer arms the machine for one vote
vote_candidate  input  NUM_CAND  one-hot vote buttons, bit i = candidate i
voting_session_done  input  1  closes the session
display_results  input  IDX_W  candidate index to query in DONE
display_winner  input  1  query the winner in DONE; has priority over display_results
candidate_name  output  IDX_W  index of the candidate being reported
invalid_results  output  1  reported result is not valid (tie or index out of range)
results  output  WIDTH  tally being reported
voting_in_progress  output  1  high in ARMED and RELEASE
voting_done  output  1  high in DONE
tie_detected  output  1  high in DONE when two or more candidates share the maximum tally

Behaviour:
- Reset (rst=0, async): state=IDLE, all tallies=0, all outputs=0.
- All outputs are registered, so every response appears one clk after the cause.
- FSM states: IDLE, WAIT_READY, ARMED, RELEASE, DONE.
- IDLE: outputs 0. switch_on_evm=1 -> WAIT_READY.
- Any state with switch_on_evm=0 -> IDLE on the next edge. All tallies clear, outputs go to 0. This has the highest priority.
- WAIT_READY: voting_session_done=1 -> DONE. Otherwise candidate_ready=1 -> ARMED.
- ARMED: voting_session_done=1 -> DONE; a vote sampled in the same cycle is discarded.
- ARMED, vote_candidate exactly one-hot (bit i): tally[i] += 1, saturating at 2^WIDTH-1 (no wrap) -> RELEASE.
- ARMED, vote_candidate=0 or multi-hot: no tally change, stay in ARMED. Multi-hot input is ignored silently.
- RELEASE: wait until vote_candidate=0 and candidate_ready=0 -> WAIT_READY. A held button never counts twice.
- RELEASE, voting_session_done=1 -> DONE.
- DONE: voting_done=1, voting_in_progress=0. Remain in DONE until switch_on_evm=0. Further vote and ready inputs are ignored.
- DONE, display_winner=1: candidate_name = lowest index holding the maximum tally, results = that tally.
  - Two or more candidates at the maximum (including all zero) -> invalid_results=1.
- DONE, display_winner=0: candidate_name=display_results.
  - display_results < NUM_CAND -> results=tally[display_results], invalid_results=0.
  - display_results >= NUM_CAND -> results=0, invalid_results=1.
- tie_detected is updated every cycle in DONE and is 0 outside DONE.
- Outside DONE: candidate_name, results, and invalid_results hold 0.
- Winner and tie evaluation is combinational over the tallies and then registered. There is no multi-cycle search.

Test Plan:
- Reset, then power on, then three ready/vote cycles for candidates 2,0,2, then session_done and display_winner=1 -> candidate_name=2, results=2, invalid_results=0, tie_detected=0, voting_done=1.
- In ARMED, apply vote_candidate=4'b0110 for 3 cycles, then 4'b0001 -> only tally[0]=1; the FSM stays in ARMED during the multi-hot cycles.
- Hold vote_candidate=4'b1000 with candidate_ready high for 10 cycles -> tally[3]=1 (counted once); WAIT_READY is reached only after both inputs are released.
- Tie: one vote each for candidates 1 and 3, then DONE, display_winner=1 -> candidate_name=1, results=1, invalid_results=1, tie_detected=1.
- Out-of-range query: NUM_CAND=3, DONE, display_results=3 -> results=0, invalid_results=1. With display_results=1 -> tally[1], invalid_results=0.
- Saturation and off: WIDTH=2, five votes for candidate 0 -> results=3. Then drop switch_on_evm mid-ARMED -> IDLE next cycle, all tallies 0. Async rst low mid-vote -> all outputs 0 immediately.

Source files
------------

// File: rtl/evm_multi_candidate_core.sv
// rtl/evm_multi_candidate_core.sv - parametrised EVM core with saturating tallies, tie and range checks
module evm_multi_candidate_core #(
  parameter int NUM_CAND = 4,
  parameter int WIDTH    = 8,
  parameter int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                switch_on_evm,
  input  logic                candidate_ready,
  input  logic [NUM_CAND-1:0] vote_candidate,
  input  logic                voting_session_done,
  input  logic [IDX_W-1:0]    display_results,
  input  logic                display_winner,
  output logic [IDX_W-1:0]    candidate_name,
  output logic                invalid_results,
  output logic [WIDTH-1:0]    results,
  output logic                voting_in_progress,
  output logic                voting_done,
  output logic                tie_detected
);

  typedef enum logic [2:0] {IDLE, WAIT_READY, ARMED, RELEASE, DONE} state_t;

  localparam logic [WIDTH-1:0] TALLY_MAX = '1;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_tally [NUM_CAND];
  logic              w_onehot;
  logic [IDX_W-1:0]  w_vote_idx;
  logic [WIDTH-1:0]  w_max;
  logic [IDX_W-1:0]  w_win_idx;
  logic              w_tie;
  logic              w_in_range;

  assign w_onehot   = $onehot(vote_candidate);
  assign w_in_range = int'(display_results) < NUM_CAND;

  always_comb begin
    w_vote_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote_candidate[i]) w_vote_idx = IDX_W'(i);
    end
  end

  // Strict '>' keeps the lowest index; an equal later tally marks a shared maximum.
  always_comb begin
    w_max     = r_tally[0];
    w_win_idx = '0;
    w_tie     = 1'b0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (r_tally[i] > w_max) begin
        w_max     = r_tally[i];
        w_win_idx = IDX_W'(i);
        w_tie     = 1'b0;
      end else if (r_tally[i] == w_max) begin
        w_tie = 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    if (!switch_on_evm) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:       w_next = WAIT_READY;
        WAIT_READY: begin
          if (voting_session_done)  w_next = DONE;
          else if (candidate_ready) w_next = ARMED;
        end
        ARMED: begin
          if (voting_session_done) w_next = DONE;
          else if (w_onehot)       w_next = RELEASE;
        end
        RELEASE: begin
          if (voting_session_done) w_next = DONE;
          else if (vote_candidate == '0 && !candidate_ready) w_next = WAIT_READY;
        end
        DONE:       w_next = DONE;
        default:    w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
    end else if (!switch_on_evm) begin
      for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
    end else if (r_state == ARMED && !voting_session_done && w_onehot) begin
      if (r_tally[w_vote_idx] != TALLY_MAX) r_tally[w_vote_idx] <= r_tally[w_vote_idx] + 1'b1;
    end
  end

  // Outputs follow the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      candidate_name     <= '0;
      invalid_results    <= 1'b0;
      results            <= '0;
      voting_in_progress <= 1'b0;
      voting_done        <= 1'b0;
      tie_detected       <= 1'b0;
    end else begin
      voting_in_progress <= (w_next == ARMED) || (w_next == RELEASE);
      voting_done        <= (w_next == DONE);
      candidate_name     <= '0;
      invalid_results    <= 1'b0;
      results            <= '0;
      tie_detected       <= 1'b0;
      if (w_next == DONE) begin
        tie_detected <= w_tie;
        if (display_winner) begin
          candidate_name  <= w_win_idx;
          results         <= w_max;
          invalid_results <= w_tie;
        end else begin
          candidate_name  <= display_results;
          if (w_in_range) begin
            results <= r_tally[display_results];
          end else begin
            invalid_results <= 1'b1;
          end
        end
      end
    end
  end

endmodule
